// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll controller and its dice counter interface.
package dice_pkg;

    localparam int DICE_W = 3;

    localparam logic [DICE_W-1:0] FACE_MAX  = 3'd6;
    localparam logic [DICE_W-1:0] FACE_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        SETTLE,
        CHECK
    } dice_state_e;

endpackage

// File: rtl/dice_roll_ctrl_btn_sync.sv
// Two-flop synchronizer for the raw roll button with a one-cycle rising-edge pulse.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic btn_s,
    output logic btn_rise
);

    logic [1:0] sync;
    logic       btn_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b00;
            btn_prev <= 1'b0;
        end else begin
            sync     <= {sync[0], btn};
            btn_prev <= sync[1];
        end
    end

    assign btn_s    = sync[1];
    assign btn_rise = sync[1] & ~btn_prev;

endmodule

// File: rtl/dice_roll_ctrl.sv
// Roll-button controller: spins the dice while held, slows it with widening gaps
// on release, then latches a 1..6 face from the dice state.
//
// state  | meaning
// IDLE   | waiting for a fresh button press
// ROLL   | button held, dice enabled every cycle
// SETTLE | slowing burst, one enable per doubling gap
// CHECK  | sample dice state, re-enable on 6/7
module dice_roll_ctrl
    import dice_pkg::*;
#(
    parameter int SETTLE_STEPS = 4,
    parameter int BASE_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              roll_btn,
    input  logic [DICE_W-1:0] q_in,
    output logic              dice_en,
    output logic [DICE_W-1:0] face,
    output logic              face_valid,
    output logic              busy,
    output logic [7:0]        roll_count
);

    localparam logic [2:0] LAST_STEP = 3'(SETTLE_STEPS - 1);
    localparam logic [7:0] FIRST_GAP = 8'(BASE_GAP - 1);

    logic        btn_s;
    logic        btn_rise;
    dice_state_e state;
    dice_state_e state_nxt;
    logic [7:0]  gap;
    logic [7:0]  gap_nxt;
    logic [2:0]  step;
    logic [2:0]  step_nxt;
    logic [8:0]  gap_span;
    logic        q_ok;
    logic        roll_done;

    btn_sync u_btn_sync (
        .clk      (clk),
        .rst      (rst),
        .btn      (roll_btn),
        .btn_s    (btn_s),
        .btn_rise (btn_rise)
    );

    assign q_ok = (q_in < FACE_MAX);
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            gap   <= 8'd0;
            step  <= 3'd0;
        end else begin
            state <= state_nxt;
            gap   <= gap_nxt;
            step  <= step_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap;
        step_nxt  = step;
        dice_en   = 1'b0;
        roll_done = 1'b0;
        // span of the following step; needs 9 bits since it may reach 256
        gap_span  = 9'(BASE_GAP) << (step + 3'd1);
        case (state)
            IDLE: begin
                if (btn_rise) begin
                    state_nxt = ROLL;
                end
            end
            ROLL: begin
                dice_en = 1'b1;
                if (!btn_s) begin
                    state_nxt = SETTLE;
                    step_nxt  = 3'd0;
                    gap_nxt   = FIRST_GAP;
                end
            end
            SETTLE: begin
                if (gap == 8'd0) begin
                    dice_en = 1'b1;
                    if (step == LAST_STEP) begin
                        state_nxt = CHECK;
                    end else begin
                        step_nxt = step + 3'd1;
                        gap_nxt  = 8'(gap_span - 9'd1);
                    end
                end else begin
                    gap_nxt = gap - 8'd1;
                end
            end
            CHECK: begin
                if (q_ok) begin
                    roll_done = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    dice_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            face       <= FACE_NONE;
            face_valid <= 1'b0;
            roll_count <= 8'd0;
        end else begin
            face_valid <= roll_done;
            if (roll_done) begin
                face       <= q_in + 3'd1;
                roll_count <= roll_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl: table of roll scenarios plus reset and wrap sequences.
module tb_dice_roll_ctrl;

    localparam int SETTLE_STEPS = 4;
    localparam int BASE_GAP     = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       roll_btn;
    logic [2:0] q_in;
    logic       dice_en;
    logic [2:0] face;
    logic       face_valid;
    logic       busy;
    logic [7:0] roll_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         hold;
        logic [2:0] qa;
        logic [2:0] qb;
        logic [2:0] exp_face;
        bit         reroll;
        int         repress;
    } roll_vec_t;

    roll_vec_t vecs[7];

    always #5 clk = ~clk;

    dice_roll_ctrl #(
        .SETTLE_STEPS (SETTLE_STEPS),
        .BASE_GAP     (BASE_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .roll_btn   (roll_btn),
        .q_in       (q_in),
        .dice_en    (dice_en),
        .face       (face),
        .face_valid (face_valid),
        .busy       (busy),
        .roll_count (roll_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Press for 'hold' cycles, then follow the expected enable/busy/valid timeline tick by tick.
    task automatic do_roll(input int hold, input logic [2:0] qa, input logic [2:0] qb,
                           input logic [2:0] exp_face, input bit reroll, input int repress,
                           input logic [7:0] exp_count, input string tag);
        int  cum;
        int  c;
        int  last_pulse;
        int  done_tick;
        int  bad;
        int  first_bad;
        logic exp_en;
        logic exp_busy;
        logic exp_fv;
        bad       = 0;
        first_bad = 0;
        cum       = 0;
        for (int k = 0; k < SETTLE_STEPS; k++) cum += BASE_GAP << k;
        last_pulse = hold + 2 + cum;
        done_tick  = last_pulse + 2 + (reroll ? 1 : 0);
        q_in     = qa;
        roll_btn = 1'b1;
        for (int t = 1; t <= done_tick + 1; t++) begin
            tick();
            if (reroll && t == last_pulse + 2) begin
                q_in = qb;
                #1;
            end
            exp_en = (t >= 3 && t <= hold + 2) || (reroll && t == last_pulse + 1);
            c = 0;
            for (int k = 0; k < SETTLE_STEPS; k++) begin
                c += BASE_GAP << k;
                if (t == hold + 2 + c) exp_en = 1'b1;
            end
            exp_busy = (t >= 3 && t < done_tick);
            exp_fv   = (t == done_tick);
            if (dice_en !== exp_en || busy !== exp_busy || face_valid !== exp_fv) begin
                if (bad == 0) first_bad = t;
                bad++;
            end
            if (t == done_tick) begin
                check({tag, "_face"}, face, exp_face);
                check({tag, "_count"}, roll_count, exp_count);
            end
            if (t == hold) roll_btn = 1'b0;
            if (repress != 0 && t == repress) roll_btn = 1'b1;
        end
        check($sformatf("%s_trace_bad_ticks(first=%0d)", tag, first_bad), bad, 0);
    endtask

    initial begin
        int bad;
        vecs[0] = '{10, 3'd4, 3'd4, 3'd5, 1'b0, 0};
        vecs[1] = '{3,  3'd6, 3'd0, 3'd1, 1'b1, 0};
        vecs[2] = '{1,  3'd0, 3'd0, 3'd1, 1'b0, 0};
        vecs[3] = '{5,  3'd5, 3'd5, 3'd6, 1'b0, 0};
        vecs[4] = '{7,  3'd7, 3'd4, 3'd5, 1'b1, 0};
        vecs[5] = '{2,  3'd3, 3'd3, 3'd4, 1'b0, 12};
        vecs[6] = '{4,  3'd1, 3'd1, 3'd2, 1'b0, 0};

        rst      = 1'b1;
        roll_btn = 1'b0;
        q_in     = 3'd0;
        for (int i = 0; i < 3; i++) begin
            roll_btn = ~roll_btn;
            tick();
            check("rst_dice_en", dice_en, 0);
        end
        check("rst_face", face, 0);
        check("rst_face_valid", face_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_roll_count", roll_count, 0);
        roll_btn = 1'b0;
        rst      = 1'b0;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy !== 1'b0 || dice_en !== 1'b0) bad++;
        end
        check("post_rst_idle", bad, 0);

        for (int i = 0; i < 7; i++) begin
            do_roll(vecs[i].hold, vecs[i].qa, vecs[i].qb, vecs[i].exp_face, vecs[i].reroll,
                    vecs[i].repress, 8'(i + 1), $sformatf("vec%0d", i));
            if (vecs[i].repress != 0) begin
                bad = 0;
                for (int t = 0; t < 10; t++) begin
                    tick();
                    if (busy !== 1'b0 || dice_en !== 1'b0) bad++;
                end
                check("held_btn_no_roll", bad, 0);
                check("held_btn_face", face, vecs[i].exp_face);
                roll_btn = 1'b0;
                repeat (4) tick();
            end else begin
                repeat (3) tick();
                check($sformatf("vec%0d_face_hold", i), face, vecs[i].exp_face);
            end
        end

        // reset landing on the third settle pulse
        roll_btn = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 4) roll_btn = 1'b0;
        end
        check("pre_rst_dice_en", dice_en, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_dice_en", dice_en, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_face", face, 0);
        check("mid_rst_roll_count", roll_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) tick();

        do_roll(1, 3'd2, 3'd2, 3'd3, 1'b0, 0, 8'd1, "post_rst");
        repeat (3) tick();
        for (int i = 0; i < 255; i++) begin
            do_roll(1, 3'd2, 3'd2, 3'd3, 1'b0, 0, 8'(i + 2), $sformatf("wrap%0d", i));
            repeat (3) tick();
        end
        check("wrap_roll_count", roll_count, 0);
        check("wrap_face", face, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
